shift_multi: RTL
================

# shift_multi

Parametrised, mode-selectable barrel shift register: loads a WIDTH-bit word and, on each enabled clock, shifts it by a programmable step in one of four modes. It reports the last bit shifted out, a cumulative shift count and a done flag. It is the multi-mode, multi-bit-step successor to the single-bit serialising shifter in the datapath library, and serves serialisers, normalisers and bit-extraction logic.

## Interface
- WIDTH, 4: data width; must be ≥ 2.
- STEP_W, 3: width of the step input; a step may exceed WIDTH.
- CNT_W, 8: width of the cumulative shift counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- w  in  WIDTH  parallel load word.
- load  in  1  load w into the register.
- en  in  1  perform one shift of `step` positions.
- mode  in  2  00 LSR (toward bit 0, zero fill), 01 LSL (toward MSB, zero fill), 10 ASR (toward bit 0, MSB fill), 11 ROR (rotate toward bit 0).
- step  in  STEP_W  shift amount for this cycle.
- y  out  WIDTH  current register contents.
- k  out  1  last bit shifted or rotated out.
- cnt  out  CNT_W  cumulative positions shifted since load; saturating.
- done  out  1  sticky; set when cnt ≥ WIDTH.

## Operation
- Reset: y=0, k=0, cnt=0, done=0, taking effect immediately and regardless of clk.
- Priority per edge: rst > load > en > hold.
- Load: y←w, k←0, cnt←0, done←0. This happens even if en is also high; no shift occurs that cycle.
- en with step=0: y, k and cnt hold.
- en with step=s>0:
  - LSR: y←y>>s with zero fill. k←y[s-1] if s≤WIDTH, else 0.
  - LSL: y←y<<s truncated to WIDTH. k←y[WIDTH-s] if s≤WIDTH, else 0.
  - ASR: y←y>>>s with MSB fill. k←y[s-1] if s≤WIDTH, else y[WIDTH-1]. If s≥WIDTH, every bit of y equals the old MSB.
  - ROR: the effective amount is r=s mod WIDTH. y←rotate-right(y,r). k←y[(s-1) mod WIDTH]. If r=0, y holds but k still updates.
  - cnt←min(cnt+s, 2^CNT_W−1), with no wrap-around. done←done | (new cnt ≥ WIDTH). done stays set until load or rst.
- mode and step may change on any cycle. Each enabled cycle uses the values present at that edge.
- en low and load low: everything holds.

## Timing
- All outputs are registered. A shift or load requested at edge N is visible right after edge N (latency one cycle).
- There is no handshake. A new operation may be issued every cycle.
- done and cnt reflect the same edge as the y update that caused them.
- rst deasserting mid-sequence leaves the block in its reset state. A fresh load is required before meaningful shifting.
- Inputs must be stable around the rising edge of clk. The block does not synchronise rst deassertion.

## Structure
- Package shift_pkg: the mode constants (SH_LSR=2'b00, SH_LSL=2'b01, SH_ASR=2'b10, SH_ROR=2'b11) and the mode typedef.
- Sub-module shift_core: a purely combinational barrel shifter.
  - Inputs: y, mode, step.
  - Outputs: next y and next k.
  - It handles s>WIDTH and the modulo for ROR.
- Top level: the y/k/cnt/done registers, priority logic and saturation.

## Test plan
WIDTH=4 unless stated.
1. Load 1111, then LSR step=1 for four cycles → y=0111, 0011, 0001, 0000. k=1 on each shift. cnt=1..4. done rises with cnt=4.
2. Load 1000, then ASR step=2 → y=1110, k=0. A second ASR step=2 → y=1111, k=1. ASR step=7 from 1000 → y=1111, k=1.
3. Load 0110, then LSL step=3 → y=0000, k=1, cnt=3, done=0. LSL step=5 from a fresh 0110 → y=0000, k=0, done=1.
4. Load 1001, then ROR step=5 → y=1100, k=1, cnt=5, done=1. ROR step=4 → y unchanged, k=y[3].
5. load and en high together with w=1010 → y=1010, cnt=0, done cleared. Assert rst between clock edges mid-sequence → all outputs read 0 immediately.
6. With CNT_W=3, repeated LSR step=3 → cnt goes 3, 6, 7, 7 (saturates, no wrap). en high with step=0 → y, k and cnt unchanged.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared mode encoding for the multi-mode barrel shift register.
package shift_pkg;

   typedef enum logic [1:0] {
      SH_LSR = 2'b00,   // logical right, zero fill
      SH_LSL = 2'b01,   // logical left, zero fill
      SH_ASR = 2'b10,   // arithmetic right, MSB fill
      SH_ROR = 2'b11    // rotate right
   } shift_mode_t;

   // Rotation amount folded into one word length.
   function automatic int rot_amount(input int s, input int width);
      return s % width;
   endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter: next word and last bit out for one step.
// Steps larger than WIDTH are legal; ROR folds them modulo WIDTH.
module shift_core
   import shift_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 3
) (
   input  logic [WIDTH-1:0]  y,
   input  shift_mode_t       mode,
   input  logic [STEP_W-1:0] step,
   output logic [WIDTH-1:0]  y_next,
   output logic              k_next
);

   int   s;
   int   r;
   int   idx;
   logic pick;
   logic fill;

   // Shifted word plus the index of the bit that leaves last.
   // When no in-range bit leaves last (step beyond the word), k takes fill.
   always_comb begin
      s      = int'(step);
      r      = rot_amount(s, WIDTH);
      y_next = y;
      idx    = 0;
      pick   = 1'b0;
      fill   = 1'b0;
      case (mode)
         SH_LSR: begin
            y_next = y >> step;
            pick   = (s <= WIDTH);
            idx    = s - 1;
         end
         SH_LSL: begin
            y_next = y << step;
            pick   = (s <= WIDTH);
            idx    = WIDTH - s;
         end
         SH_ASR: begin
            y_next = $unsigned($signed(y) >>> step);
            pick   = (s <= WIDTH);
            idx    = s - 1;
            fill   = y[WIDTH-1];
         end
         SH_ROR: begin
            for (int i = 0; i < WIDTH; i++) begin
               y_next[i] = y[(i + r) % WIDTH];
            end
            pick = 1'b1;
            idx  = (s == 0) ? 0 : rot_amount(s - 1, WIDTH);
         end
         default: ;
      endcase
   end

   // Select the outgoing bit without a variable part-select on y.
   always_comb begin
      k_next = fill;
      if (pick) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (idx == i) begin
               k_next = y[i];
            end
         end
      end
   end

endmodule

// File: rtl/shift_multi.sv
// Mode-selectable barrel shift register with last-bit-out, saturating
// cumulative shift count and sticky done flag.
module shift_multi
   import shift_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  w,
   input  logic              load,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [STEP_W-1:0] step,
   output logic [WIDTH-1:0]  y,
   output logic              k,
   output logic [CNT_W-1:0]  cnt,
   output logic              done
);

   // One spare bit above the wider operand so the add never wraps.
   localparam int SUM_W = ((CNT_W > STEP_W) ? CNT_W : STEP_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] y_next;
   logic             k_next;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt_sat;
   logic             done_hit;
   logic             shift_go;

   shift_core #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_core (
      .y      (y),
      .mode   (shift_mode_t'(mode)),
      .step   (step),
      .y_next (y_next),
      .k_next (k_next)
   );

   // Saturating count update and the done threshold on the new count.
   always_comb begin
      sum      = SUM_W'(cnt) + SUM_W'(step);
      cnt_sat  = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
      done_hit = (int'(cnt_sat) >= WIDTH);
      shift_go = en && (step != '0);
   end

   // Register update: rst over load over shift; zero step holds everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y    <= '0;
         k    <= 1'b0;
         cnt  <= '0;
         done <= 1'b0;
      end else if (load) begin
         y    <= w;
         k    <= 1'b0;
         cnt  <= '0;
         done <= 1'b0;
      end else if (shift_go) begin
         y    <= y_next;
         k    <= k_next;
         cnt  <= cnt_sat;
         done <= done | done_hit;
      end
   end

endmodule
